// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: bit-slip word alignment on control tokens, then 10b->8b decode.
// Latency 2 cycles from aligned window to vd/cd/vde; no backpressure, one word accepted every clk_pixel.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int DWELL_WORDS = 1024,
  parameter int LOSS_WORDS  = 2048
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       aligned,
  output logic [3:0] bit_offset
);

  localparam int RUN_W   = $clog2(LOCK_TOKENS + 1);
  localparam int DWELL_W = $clog2(DWELL_WORDS + 1);
  localparam int LOSS_W  = $clog2(LOSS_WORDS + 1);

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_TOKENS - 1);
  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(LOCK_TOKENS);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_WORDS - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_WORDS - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [9:0]           prev_word;
  logic [9:0]           s1_word;
  logic [9:0]           word_al;
  logic                 slip_d;
  logic                 slip;
  logic [RUN_W-1:0]     run_cnt, run_nxt;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_nxt;
  logic [LOSS_W-1:0]    loss_cnt, loss_nxt;
  logic [3:0]           offset_q, offset_nxt;
  logic                 tok_hit;
  logic [1:0]           tok_cd;
  logic [7:0]           data_dec;
  logic [7:0]           q_unmask;
  logic [7:0]           vd_nxt;
  logic [1:0]           cd_nxt;
  logic                 vde_nxt;

  // Window bit 0 is the oldest received bit; offset picks the 10-bit word start.
  always_comb begin
    word_al = '0;
    unique case (offset_q)
      4'd0: word_al = prev_word;
      4'd1: word_al = {tmds_in[0],   prev_word[9:1]};
      4'd2: word_al = {tmds_in[1:0], prev_word[9:2]};
      4'd3: word_al = {tmds_in[2:0], prev_word[9:3]};
      4'd4: word_al = {tmds_in[3:0], prev_word[9:4]};
      4'd5: word_al = {tmds_in[4:0], prev_word[9:5]};
      4'd6: word_al = {tmds_in[5:0], prev_word[9:6]};
      4'd7: word_al = {tmds_in[6:0], prev_word[9:7]};
      4'd8: word_al = {tmds_in[7:0], prev_word[9:8]};
      4'd9: word_al = {tmds_in[8:0], prev_word[9]};
      default: word_al = '0;
    endcase
  end

  always_comb begin
    tok_hit = 1'b1;
    tok_cd  = 2'b00;
    unique case (s1_word)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  always_comb begin
    q_unmask    = s1_word[9] ? ~s1_word[7:0] : s1_word[7:0];
    data_dec    = '0;
    data_dec[0] = q_unmask[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = s1_word[8] ? (q_unmask[i] ^ q_unmask[i-1]) : ~(q_unmask[i] ^ q_unmask[i-1]);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state     <= SEARCH;
      prev_word <= '0;
      s1_word   <= '0;
      slip_d    <= 1'b0;
      run_cnt   <= '0;
      dwell_cnt <= '0;
      loss_cnt  <= '0;
      offset_q  <= '0;
      vd        <= '0;
      cd        <= '0;
      vde       <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_word <= tmds_in;
      s1_word   <= word_al;
      slip_d    <= slip;
      run_cnt   <= run_nxt;
      dwell_cnt <= dwell_nxt;
      loss_cnt  <= loss_nxt;
      offset_q  <= offset_nxt;
      vd        <= vd_nxt;
      cd        <= cd_nxt;
      vde       <= vde_nxt;
    end
  end

  // The word right after a slip was captured at the old offset, so it cannot build a run.
  always_comb begin
    state_nxt  = state;
    run_nxt    = run_cnt;
    dwell_nxt  = dwell_cnt;
    loss_nxt   = loss_cnt;
    offset_nxt = offset_q;
    slip       = 1'b0;
    unique case (state)
      SEARCH: begin
        if (!slip_d && tok_hit && (run_cnt >= RUN_LAST)) begin
          state_nxt = LOCKED;
          run_nxt   = '0;
          dwell_nxt = '0;
          loss_nxt  = '0;
        end else if (dwell_cnt >= DWELL_LAST) begin
          slip       = 1'b1;
          offset_nxt = (offset_q >= 4'd9) ? 4'd0 : offset_q + 4'd1;
          run_nxt    = '0;
          dwell_nxt  = '0;
        end else begin
          if (slip_d || !tok_hit) run_nxt = '0;
          else if (run_cnt != RUN_MAX) run_nxt = run_cnt + 1'b1;
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (tok_hit) begin
          loss_nxt = '0;
        end else if (loss_cnt >= LOSS_LAST) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          dwell_nxt = '0;
          loss_nxt  = '0;
        end else begin
          loss_nxt = loss_cnt + 1'b1;
        end
      end
    endcase
  end

  // Outputs are gated with the next state so they are zero exactly while aligned is low.
  always_comb begin
    aligned    = (state == LOCKED);
    bit_offset = offset_q;
    vd_nxt     = '0;
    cd_nxt     = '0;
    vde_nxt    = 1'b0;
    if (state_nxt == LOCKED) begin
      if (tok_hit) begin
        cd_nxt = tok_cd;
      end else begin
        vde_nxt = 1'b1;
        vd_nxt  = data_dec;
        cd_nxt  = cd;
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: bit-stream reference model checked every cycle,
// decode vector table, and hand sequences for lock, slip, loss and reset timing.
module tb_tmds_channel_decoder;

  localparam int LOCK_TOKENS = 8;
  localparam int DWELL_WORDS = 1024;
  localparam int LOSS_WORDS  = 2048;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       aligned;
  logic [3:0] bit_offset;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .LOCK_TOKENS(LOCK_TOKENS),
    .DWELL_WORDS(DWELL_WORDS),
    .LOSS_WORDS (LOSS_WORDS)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .tmds_in   (tmds_in),
    .vd        (vd),
    .cd        (cd),
    .vde       (vde),
    .aligned   (aligned),
    .bit_offset(bit_offset)
  );

  int vectors = 0;
  int miscompares = 0;
  int shift = 0;
  logic [9:0] last_tx = '0;

  // ---------------- reference model ----------------
  logic [9:0] m_prev, m_s1;
  int         m_off, m_run, m_dwell, m_loss;
  bit         m_locked, m_ign;
  logic [7:0] m_vd;
  logic [1:0] m_cd;
  bit         m_vde;

  function automatic int tok_index(input logic [9:0] w);
    logic [9:0] toks [4];
    toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
    for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int k = 1; k < 8; k++) d[k] = (b[k] == b[k-1]) ? !q[8] : q[8];
    return d;
  endfunction

  always @(posedge clk_pixel) begin
    logic [19:0] win;
    int t, off, run, dwell, loss;
    bit lk, slip, nvde;
    logic [7:0] nvd;
    logic [1:0] ncd;
    if (reset) begin
      m_prev <= '0; m_s1 <= '0; m_off <= 0; m_run <= 0; m_dwell <= 0; m_loss <= 0;
      m_locked <= 0; m_ign <= 0; m_vd <= '0; m_cd <= '0; m_vde <= 0;
    end else begin
      win = {tmds_in, m_prev};
      t = tok_index(m_s1);
      off = m_off; run = m_run; dwell = m_dwell; loss = m_loss; lk = m_locked; slip = 0;
      if (!lk) begin
        if (!m_ign && t >= 0 && run + 1 >= LOCK_TOKENS) begin
          lk = 1; run = 0; dwell = 0; loss = 0;
        end else if (dwell >= DWELL_WORDS - 1) begin
          slip = 1; off = (off + 1) % 10; run = 0; dwell = 0;
        end else begin
          run = (!m_ign && t >= 0) ? run + 1 : 0;
          dwell = dwell + 1;
        end
      end else if (t >= 0) begin
        loss = 0;
      end else if (loss + 1 >= LOSS_WORDS) begin
        lk = 0; run = 0; dwell = 0; loss = 0;
      end else begin
        loss = loss + 1;
      end
      nvd = '0; ncd = '0; nvde = 0;
      if (lk) begin
        if (t >= 0) ncd = 2'(t);
        else begin nvde = 1; nvd = ref_data(m_s1); ncd = m_cd; end
      end
      m_s1 <= 10'(win >> m_off);
      m_prev <= tmds_in;
      m_off <= off; m_run <= run; m_dwell <= dwell; m_loss <= loss;
      m_locked <= lk; m_ign <= slip;
      m_vd <= nvd; m_cd <= ncd; m_vde <= nvde;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [9:0] w);
    tmds_in = w;
    @(negedge clk_pixel);
    vectors++;
    if ({vd, cd, vde, aligned, bit_offset} !== {m_vd, m_cd, m_vde, m_locked, 4'(m_off)}) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL model t=%0t got vd=%h cd=%b vde=%b al=%b off=%0d want vd=%h cd=%b vde=%b al=%b off=%0d",
                 $time, vd, cd, vde, aligned, bit_offset, m_vd, m_cd, m_vde, m_locked, m_off);
    end
  endtask

  // Sends one transmitter word; the receiver sees it delayed by 'shift' bits.
  task automatic send(input logic [9:0] w);
    logic [19:0] pair;
    pair = {w, last_tx};
    last_tx = w;
    step(10'(pair >> (10 - shift)));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(10'h0);
    step(10'h0);
    reset = 1'b0;
    shift = 0;
    last_tx = '0;
  endtask

  typedef struct {
    logic [9:0] w;
    logic       e_vde;
    logic [7:0] e_vd;
    logic [1:0] e_cd;
  } vec_t;

  vec_t tab [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tab[0]  = '{10'b0100000000, 1'b1, 8'h00, 2'b00};
    tab[1]  = '{10'b1000000000, 1'b1, 8'hFF, 2'b00};
    tab[2]  = '{T11,            1'b0, 8'h00, 2'b11};
    tab[3]  = '{10'h101,        1'b1, 8'h03, 2'b11};
    tab[4]  = '{10'h001,        1'b1, 8'hFD, 2'b11};
    tab[5]  = '{T01,            1'b0, 8'h00, 2'b01};
    tab[6]  = '{10'h3FF,        1'b1, 8'h00, 2'b01};
    tab[7]  = '{T10,            1'b0, 8'h00, 2'b10};
    tab[8]  = '{10'h2AA,        1'b1, 8'h01, 2'b10};
    tab[9]  = '{10'h1AA,        1'b1, 8'hFE, 2'b10};
    tab[10] = '{T00,            1'b0, 8'h00, 2'b00};
    tab[11] = '{10'h0F0,        1'b1, 8'hEE, 2'b00};
    tab[12] = '{T00,            1'b0, 8'h00, 2'b00};

    // Reset state
    do_reset();
    chk("reset_vd", int'(vd), 0);
    chk("reset_cd", int'(cd), 0);
    chk("reset_vde", int'(vde), 0);
    chk("reset_aligned", int'(aligned), 0);
    chk("reset_offset", int'(bit_offset), 0);

    // Eight tokens at offset 0: lock two cycles after the 8th word
    for (int i = 0; i < 8; i++) send(T00);
    send(T00);
    chk("lock_early", int'(aligned), 0);
    send(T00);
    chk("lock_on_time", int'(aligned), 1);
    chk("lock_offset0", int'(bit_offset), 0);

    // Decode table, pipelined: entry i-2 appears after driving entry i
    for (int i = 0; i < 15; i++) begin
      send(i < 13 ? tab[i].w : T00);
      if (i >= 2) begin
        vectors++;
        if ({vde, vd, cd, aligned} !== {tab[i-2].e_vde, tab[i-2].e_vd, tab[i-2].e_cd, 1'b1}) begin
          miscompares++;
          $display("FAIL table[%0d] got vde=%b vd=%h cd=%b al=%b want vde=%b vd=%h cd=%b al=1",
                   i - 2, vde, vd, cd, aligned, tab[i-2].e_vde, tab[i-2].e_vd, tab[i-2].e_cd);
        end
      end
    end

    // Loss of lock after LOSS_WORDS non-tokens
    for (int i = 0; i < LOSS_WORDS; i++) send(10'h0F0);
    send(10'h0F0);
    chk("loss_not_yet", int'(aligned), 1);
    send(10'h0F0);
    chk("loss_aligned", int'(aligned), 0);
    chk("loss_offset_kept", int'(bit_offset), 0);
    chk("loss_vde_forced", int'(vde), 0);
    chk("loss_vd_forced", int'(vd), 0);

    // 8th token evaluated on the dwell-expiry cycle: lock wins
    do_reset();
    for (int i = 1; i <= 1014; i++) send(10'h000);
    for (int i = 1015; i <= 1022; i++) send(T00);
    send(10'h000);
    chk("dwell_tie_before", int'(aligned), 0);
    send(10'h000);
    chk("dwell_tie_aligned", int'(aligned), 1);
    chk("dwell_tie_offset", int'(bit_offset), 0);

    // Token stream delayed by 3 bits: three slips, then lock
    do_reset();
    shift = 3;
    n = 0;
    while (!aligned && n < 4000) begin
      send(T00);
      n++;
    end
    chk("slip3_words_to_lock", n, 3081);
    chk("slip3_offset", int'(bit_offset), 3);

    // Reset pulse while locked and decoding data
    for (int i = 0; i < 6; i++) send(10'h101);
    reset = 1'b1;
    step(10'h101);
    reset = 1'b0;
    shift = 0;
    last_tx = '0;
    chk("rst_pulse_outputs", int'({vd, cd, vde, aligned, bit_offset}), 0);
    for (int i = 0; i < 7; i++) send(T01);
    send(10'h0F0);
    send(10'h0F0);
    chk("relock_needs_8", int'(aligned), 0);
    for (int i = 0; i < 10; i++) send(T01);
    chk("relock_aligned", int'(aligned), 1);
    chk("relock_offset", int'(bit_offset), 0);

    // Random traffic while locked, then random shifted search traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 3))
          0: send(T00);
          1: send(T01);
          2: send(T10);
          default: send(T11);
        endcase
      end else begin
        send(10'($urandom));
      end
    end
    do_reset();
    shift = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) < 8) send(($urandom_range(0, 1) == 0) ? T10 : T11);
      else send(10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
